// File: rtl/mips_alu_mul_div_unit_if.sv
// Request/response bundle between the ALU issue stage and the HI/LO multiply/divide unit.
// The requester drives the master side and the unit drives the slave side.
interface mips_alu_mul_div_unit_if;
   logic        start;
   logic [3:0]  func;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] result;

   modport master (
      output start, func, a, b, flush,
      input  busy, done, hi, lo, result
   );

   modport slave (
      input  start, func, a, b, flush,
      output busy, done, hi, lo, result
   );
endinterface

// File: rtl/mips_alu_mul_div_unit.sv
// Iterative 32-cycle radix-2 multiply/divide unit owning the MIPS HI/LO registers.
// Signed operations run on magnitudes and fix up signs when HI/LO are written.
module mips_alu_mul_div_unit (
   input logic                    clock,
   input logic                    reset,
   mips_alu_mul_div_unit_if.slave bus
);
   localparam logic [3:0] FUNC_MULS = 4'd1;
   localparam logic [3:0] FUNC_MULU = 4'd2;
   localparam logic [3:0] FUNC_DIVS = 4'd3;
   localparam logic [3:0] FUNC_DIVU = 4'd4;
   localparam logic [3:0] FUNC_MTHI = 4'd5;
   localparam logic [3:0] FUNC_MTLO = 4'd6;
   localparam logic [3:0] FUNC_MFHI = 4'd7;
   localparam logic [3:0] FUNC_MFLO = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e      state_r, state_s;
   logic [4:0]  cnt_r;
   logic [3:0]  op_r;
   logic        neg_q_r, neg_r_r;
   logic [31:0] opnd_r;
   logic [63:0] work_r;
   logic [31:0] hi_r, lo_r, hi_s, lo_s;

   logic        is_mul_s, is_div_s, signed_s, can_accept_s;
   logic        accept_iter_s, accept_mthi_s, accept_mtlo_s, last_s, op_is_mul_s;
   logic [31:0] mag_a_s, mag_b_s;
   logic [32:0] mul_sum_s, div_shift_s;
   logic [31:0] div_sub_s;
   logic [63:0] work_next_s, mul_final_s;
   logic [31:0] div_q_s, div_r_s;

   assign is_mul_s      = (bus.func == FUNC_MULS) || (bus.func == FUNC_MULU);
   assign is_div_s      = (bus.func == FUNC_DIVS) || (bus.func == FUNC_DIVU);
   assign signed_s      = (bus.func == FUNC_MULS) || (bus.func == FUNC_DIVS);
   assign can_accept_s  = (state_r != ST_CALC) && bus.start && !bus.flush;
   assign accept_iter_s = can_accept_s && (is_mul_s || is_div_s);
   assign accept_mthi_s = can_accept_s && (bus.func == FUNC_MTHI);
   assign accept_mtlo_s = can_accept_s && (bus.func == FUNC_MTLO);
   assign last_s        = (state_r == ST_CALC) && (cnt_r == 5'd31);
   assign op_is_mul_s   = (op_r == FUNC_MULS) || (op_r == FUNC_MULU);
   assign mag_a_s       = (signed_s && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
   assign mag_b_s       = (signed_s && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

   // Sequential state register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; flush wins over any start.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_iter_s) state_s = ST_CALC;
            else               state_s = ST_IDLE;
         end
         ST_CALC: begin
            if (bus.flush)   state_s = ST_IDLE;
            else if (last_s) state_s = ST_DONE;
            else             state_s = ST_CALC;
         end
         ST_DONE: begin
            if (accept_iter_s) state_s = ST_CALC;
            else               state_s = ST_IDLE;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // One radix-2 step plus the sign-corrected final HI/LO values and register updates.
   always_comb begin
      mul_sum_s   = {1'b0, work_r[63:32]} + (work_r[0] ? {1'b0, opnd_r} : 33'd0);
      // Restoring divide: work_r holds {partial remainder, remaining dividend bits / quotient}.
      div_shift_s = {work_r[63:32], work_r[31]};
      div_sub_s   = div_shift_s[31:0] - opnd_r;
      if (op_is_mul_s) begin
         work_next_s = {mul_sum_s, work_r[31:1]};
      end else if (div_shift_s >= {1'b0, opnd_r}) begin
         work_next_s = {div_sub_s, work_r[30:0], 1'b1};
      end else begin
         work_next_s = {div_shift_s[31:0], work_r[30:0], 1'b0};
      end
      mul_final_s = neg_q_r ? (~work_next_s + 64'd1) : work_next_s;
      div_q_s     = neg_q_r ? (~work_next_s[31:0] + 32'd1) : work_next_s[31:0];
      div_r_s     = neg_r_r ? (~work_next_s[63:32] + 32'd1) : work_next_s[63:32];

      hi_s = hi_r;
      lo_s = lo_r;
      if (last_s && !bus.flush) begin
         if (op_is_mul_s) begin
            hi_s = mul_final_s[63:32];
            lo_s = mul_final_s[31:0];
         end else begin
            hi_s = div_r_s;
            lo_s = div_q_s;
         end
      end else if (accept_mthi_s) begin
         hi_s = bus.a;
      end else if (accept_mtlo_s) begin
         lo_s = bus.a;
      end else begin
         hi_s = hi_r;
      end
   end

   // Operand capture, iteration datapath and HI/LO registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_r   <= 5'd0;
         op_r    <= 4'd0;
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         opnd_r  <= 32'd0;
         work_r  <= 64'd0;
         hi_r    <= 32'd0;
         lo_r    <= 32'd0;
      end else begin
         hi_r <= hi_s;
         lo_r <= lo_s;
         if (accept_iter_s) begin
            cnt_r   <= 5'd0;
            op_r    <= bus.func;
            neg_q_r <= signed_s && (bus.a[31] ^ bus.b[31]);
            neg_r_r <= signed_s && is_div_s && bus.a[31];
            opnd_r  <= is_mul_s ? mag_a_s : mag_b_s;
            work_r  <= {32'd0, (is_mul_s ? mag_b_s : mag_a_s)};
         end else if (state_r == ST_CALC) begin
            cnt_r  <= cnt_r + 5'd1;
            work_r <= work_next_s;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign bus.busy = (state_r == ST_CALC);
   assign bus.done = (state_r == ST_DONE);
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

   // Move-from read path straight off the HI/LO registers.
   always_comb begin
      case (bus.func)
         FUNC_MFHI: bus.result = hi_r;
         FUNC_MFLO: bus.result = lo_r;
         default:   bus.result = 32'd0;
      endcase
   end
endmodule

// File: tb/tb_mips_alu_mul_div_unit.sv
// Directed and randomised bench for the HI/LO multiply/divide unit.
// Expected HI/LO pairs are queued at issue time and popped when done pulses.
module tb_mips_alu_mul_div_unit;
   localparam logic [3:0] F_NOP  = 4'd0;
   localparam logic [3:0] F_MULS = 4'd1;
   localparam logic [3:0] F_MULU = 4'd2;
   localparam logic [3:0] F_DIVS = 4'd3;
   localparam logic [3:0] F_DIVU = 4'd4;
   localparam logic [3:0] F_MTHI = 4'd5;
   localparam logic [3:0] F_MTLO = 4'd6;
   localparam logic [3:0] F_MFHI = 4'd7;
   localparam logic [3:0] F_MFLO = 4'd8;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;
   logic [31:0] exp_hi_q[$];
   logic [31:0] exp_lo_q[$];

   always #5 clock = ~clock;

   mips_alu_mul_div_unit_if bus ();

   mips_alu_mul_div_unit dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [63:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, q, r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (f)
         F_MULU: return {32'd0, a} * {32'd0, b};
         F_MULS: return sa * sb;
         F_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            else            return {a % b, a / b};
         end
         F_DIVS: begin
            if (b == 32'd0) return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: return 64'd0;
      endcase
   endfunction

   task automatic push(input logic [31:0] h, input logic [31:0] l);
      exp_hi_q.push_back(h);
      exp_lo_q.push_back(l);
   endtask

   task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.func  = f;
      bus.a     = a;
      bus.b     = b;
      @(negedge clock);
      bus.start = 1'b0;
      bus.func  = F_NOP;
   endtask

   task automatic wait_done(input string tag, input int exp_busy);
      int          cyc = 0;
      int          nbusy = 0;
      logic        held = 1'b1;
      logic [31:0] hi0, lo0, eh, el;
      hi0 = bus.hi;
      lo0 = bus.lo;
      while (!bus.done && cyc < 45) begin
         if (bus.busy) nbusy++;
         if (bus.hi !== hi0 || bus.lo !== lo0) held = 1'b0;
         @(negedge clock);
         cyc++;
      end
      chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
      chk({tag, "_busy_cycles"}, nbusy, exp_busy);
      chk({tag, "_latency"}, cyc, exp_busy);
      chk({tag, "_hilo_held"}, {31'd0, held}, 32'd1);
      chk({tag, "_busy_low_in_done"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, "_sb_nonempty"}, {31'd0, (exp_hi_q.size() != 0)}, 32'd1);
      if (exp_hi_q.size() != 0) begin
         eh = exp_hi_q.pop_front();
         el = exp_lo_q.pop_front();
         chk({tag, "_hi"}, bus.hi, eh);
         chk({tag, "_lo"}, bus.lo, el);
      end
   endtask

   task automatic watch_no_done(input string tag);
      logic seen = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (bus.done) seen = 1'b1;
      end
      chk(tag, {31'd0, seen}, 32'd0);
   endtask

   initial begin
      logic [3:0]  ops[4];
      logic [3:0]  f;
      logic [31:0] ra, rb;
      logic [63:0] e64;
      ops[0] = F_MULU; ops[1] = F_MULS; ops[2] = F_DIVU; ops[3] = F_DIVS;
      bus.start = 1'b0; bus.func = F_NOP; bus.a = 32'd0; bus.b = 32'd0; bus.flush = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      reset = 1'b1;
      @(negedge clock);

      push(32'hFFFF_FFFE, 32'h0000_0001);
      issue(F_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mulu_max", 32);
      @(negedge clock);
      chk("done_one_cycle", {31'd0, bus.done}, 32'd0);

      push(32'hFFFF_FFFF, 32'hFFFF_FFF1);
      issue(F_MULS, 32'hFFFF_FFFD, 32'd5);
      wait_done("muls_neg", 32);
      push(32'd0, 32'd6);
      issue(F_MULU, 32'd2, 32'd3);
      wait_done("b2b_mulu", 32);

      push(32'hFFFF_FFFF, 32'hFFFF_FFFD);
      issue(F_DIVS, 32'hFFFF_FFF9, 32'd2);
      wait_done("divs_neg", 32);
      push(32'h0000_0007, 32'hFFFF_FFFF);
      issue(F_DIVU, 32'd7, 32'd0);
      wait_done("divu_zero", 32);
      push(32'h0000_0000, 32'h8000_0000);
      issue(F_DIVS, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("divs_ovf", 32);

      issue(F_MTHI, 32'h1234_5678, 32'd0);
      bus.func = F_MFHI;
      #1;
      chk("mthi_result", bus.result, 32'h1234_5678);
      chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
      chk("mthi_done", {31'd0, bus.done}, 32'd0);
      bus.func = F_MFLO;
      #1;
      chk("mflo_result", bus.result, 32'h8000_0000);
      bus.func = F_MULU;
      #1;
      chk("other_result", bus.result, 32'd0);
      bus.func = F_NOP;
      @(negedge clock);

      push(32'd1, 32'd0);
      issue(F_MULU, 32'h0001_0000, 32'h0001_0000);
      bus.start = 1'b1; bus.func = F_MTLO; bus.a = 32'hDEAD_BEEF;
      @(negedge clock);
      bus.start = 1'b0; bus.func = F_NOP;
      chk("mtlo_in_calc_lo", bus.lo, 32'h8000_0000);
      chk("mtlo_in_calc_busy", {31'd0, bus.busy}, 32'd1);
      wait_done("mul_after_mtlo", 31);

      @(negedge clock);
      issue(4'hF, 32'hCAFE_0000, 32'd1);
      chk("bad_func_busy", {31'd0, bus.busy}, 32'd0);
      chk("bad_func_lo", bus.lo, 32'd0);

      bus.flush = 1'b1;
      issue(F_MULU, 32'd9, 32'd9);
      bus.flush = 1'b0;
      chk("flush_beats_start", {31'd0, bus.busy}, 32'd0);

      issue(F_MULU, 32'd5, 32'd7);
      repeat (9) @(negedge clock);
      bus.flush = 1'b1;
      @(negedge clock);
      bus.flush = 1'b0;
      chk("flush_busy", {31'd0, bus.busy}, 32'd0);
      chk("flush_hi", bus.hi, 32'd1);
      chk("flush_lo", bus.lo, 32'd0);
      watch_no_done("flush_no_done");

      for (int i = 0; i < 6; i++) begin
         f  = ops[i % 4];
         ra = $urandom;
         rb = (i == 5) ? 32'd0 : ((i == 4) ? 32'($urandom_range(1, 255)) : $urandom);
         e64 = model(f, ra, rb);
         push(e64[63:32], e64[31:0]);
         issue(f, ra, rb);
         wait_done("rand_op", 32);
      end

      issue(F_DIVU, 32'd100, 32'd7);
      repeat (4) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      chk("midrst_hi", bus.hi, 32'd0);
      chk("midrst_lo", bus.lo, 32'd0);
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      watch_no_done("midrst_no_done");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mips_alu_mul_div_unit.md
MIPS_ALU_MUL_DIV_UNIT -- requirements
Module: Mips_Alu_mulDivUnit

Interface
REQ-001 SHALL have ports: clock  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-low reset.
REQ-003 SHALL have ports: start  input  1  request strobe, qualified by func.
REQ-004 SHALL have ports: func  input  Mips_Alu_Func width  operation code from the ALU func decode stage.
REQ-005 SHALL have ports: a  input  32  rs operand (dividend, multiplicand, Mthi/Mtlo source).
REQ-006 SHALL have ports: b  input  32  rt operand (divisor, multiplier).
REQ-007 SHALL have ports: flush  input  1  cancels any in-flight operation.
REQ-008 SHALL have ports: busy  output  1  iterative operation in progress.
REQ-009 SHALL have ports: done  output  1  one-cycle pulse when HI/LO take a mul/div result.
REQ-010 SHALL have ports: hi  output  32  HI register.
REQ-011 SHALL have ports: lo  output  32  LO register.
REQ-012 SHALL have ports: result  output  32  combinational read: hi for Mfhi, lo for Mflo, 0 otherwise.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and DONE; busy SHALL be 1 only in CALC.
REQ-014 SHALL accept start only in IDLE or DONE; start in CALC SHALL be ignored with no state change.
REQ-015 SHALL, on an accepted start with func Muls, Mulu, Divs or Divu, latch a, b, func and the operand signs, clear a 5-bit counter and enter CALC at that edge.
REQ-016 SHALL, in CALC, perform one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes) and increment the counter each edge.
REQ-017 SHALL, on the CALC edge with counter = 31, write hi/lo and enter DONE: busy is high for exactly 32 cycles and results are visible 32 edges after the accept edge.
REQ-018 SHALL hold done = 1 for exactly the DONE cycle; DONE -> IDLE, or DONE -> CALC if a new mul/div start is accepted.
REQ-019 SHALL keep hi/lo at their previous values throughout CALC; they SHALL NOT expose partial results.
REQ-020 SHALL, for Mulu, set {hi,lo} = the 64-bit unsigned product.
REQ-021 SHALL, for Muls, set {hi,lo} = the 64-bit two's-complement product.
REQ-022 SHALL, for Divu, set lo = unsigned quotient and hi = unsigned remainder.
REQ-023 SHALL, for Divs, truncate the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-024 SHALL, on divide by zero, set hi = a; lo = 0xFFFFFFFF for Divu; for Divs, lo = 0x00000001 if a is negative, else 0xFFFFFFFF. The operation SHALL still take 32 cycles.
REQ-025 SHALL, for Divs 0x80000000 / 0xFFFFFFFF, set lo = 0x80000000 and hi = 0.
REQ-026 SHALL, on an accepted start with Mthi (Mtlo), write hi (lo) = a at that edge, with no busy and no done.
REQ-027 SHALL ignore start with any other func, with no state change.
REQ-028 SHALL, on flush in CALC, return to IDLE at the next edge, discard the operation, leave hi/lo unchanged and not assert done.
REQ-029 SHALL give flush priority over a simultaneous start; flush in IDLE or DONE SHALL force IDLE.
REQ-030 SHALL give result a zero-cycle path from the hi/lo registers, so Mfhi/Mflo read the pre-edge value; stalling readers on busy is the pipeline's responsibility.

Reset
REQ-031 SHALL, when reset = 0 at a rising edge, force state = IDLE, counter = 0, hi = 0, lo = 0, busy = 0 and done = 0, with priority over flush and start.
REQ-032 SHALL, on reset asserted mid-CALC, abandon the operation with no done pulse, and zero hi/lo rather than hold them.

Verification
REQ-033 SHALL cover: Mulu a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 32 cycles, done pulse, hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 SHALL cover: Muls a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then back-to-back Mulu 2x3 started in the DONE cycle -> hi=0, lo=6 exactly 32 edges later.
REQ-035 SHALL cover: Divs a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; Divu a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-036 SHALL cover: Divs a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-037 SHALL cover: Mthi a=0x12345678, then Mfhi -> result=0x12345678 the next cycle; a Mtlo start during busy leaves lo unchanged.
REQ-038 SHALL cover: flush on CALC cycle 10 -> busy=0 next cycle, hi/lo unchanged, no done; reset=0 on CALC cycle 5 -> hi=lo=0, busy=0, no done.
